// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } md_state_e;

endpackage

// File: rtl/multdiv_sign_fix.sv
// Applies operand signs to the unsigned product, quotient and remainder.
module multdiv_sign_fix
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             op_div,
    input  logic             sign_a,
    input  logic             sign_b,
    input  logic [WIDTH-1:0] raw_hi,
    input  logic [WIDTH-1:0] raw_lo,
    output logic [WIDTH-1:0] fix_hi,
    output logic [WIDTH-1:0] fix_lo
);

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_neg_s;

    // Remainder follows the dividend sign; quotient and product follow sign_a ^ sign_b.
    always_comb begin
        prod_s     = {raw_hi, raw_lo};
        prod_neg_s = ~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
        if (op_div == MD_OP_DIV) begin
            if (sign_a ^ sign_b) begin
                fix_lo = ~raw_lo + {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
                fix_lo = raw_lo;
            end
            if (sign_a) begin
                fix_hi = ~raw_hi + {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
                fix_hi = raw_hi;
            end
        end else begin
            if (sign_a ^ sign_b) begin
                {fix_hi, fix_lo} = prod_neg_s;
            end else begin
                {fix_hi, fix_lo} = prod_s;
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit producing HI/LO. Optional macro
// MULTDIV_UNSIGNED_EN adds an is_unsigned input selecting multu/divu semantics.
module mult_div_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
`ifdef MULTDIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    md_state_e        state_r, next_state_s;
    logic [CW-1:0]    count_r;
    logic             op_div_r, sign_a_r, sign_b_r;
    logic [WIDTH-1:0] operand_r, acc_hi_r, acc_lo_r;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             busy_r, done_r, div_zero_r;

    logic             unsigned_s, neg_a_s, neg_b_s, zero_div_s;
    logic [WIDTH-1:0] mag_a_s, mag_b_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH+1:0] div_shift_s, div_diff_s;
    logic [WIDTH-1:0] step_hi_s, step_lo_s;
    logic [WIDTH-1:0] fix_hi_s, fix_lo_s;

`ifdef MULTDIV_UNSIGNED_EN
    assign unsigned_s = is_unsigned;
`else
    assign unsigned_s = 1'b0;
`endif

    // Operand sign detection and magnitudes; 0x80..0 maps to unsigned 2^(WIDTH-1).
    always_comb begin
        neg_a_s    = ~unsigned_s & src_a[WIDTH-1];
        neg_b_s    = ~unsigned_s & src_b[WIDTH-1];
        zero_div_s = (op_div == MD_OP_DIV) && (src_b == {WIDTH{1'b0}});
        if (neg_a_s) begin
            mag_a_s = ~src_a + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag_a_s = src_a;
        end
        if (neg_b_s) begin
            mag_b_s = ~src_b + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            mag_b_s = src_b;
        end
    end

    // One shift-add or restoring shift-subtract step on the shared accumulator.
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r} +
                      (acc_lo_r[0] ? {1'b0, operand_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {1'b0, acc_hi_r, acc_lo_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {2'b00, operand_r};
        if (op_div_r == MD_OP_DIV) begin
            if (!div_diff_s[WIDTH+1]) begin
                step_hi_s = div_diff_s[WIDTH-1:0];
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_s = div_shift_s[WIDTH-1:0];
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end
    end

    multdiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .op_div (op_div_r),
        .sign_a (sign_a_r),
        .sign_b (sign_b_r),
        .raw_hi (acc_hi_r),
        .raw_lo (acc_lo_r),
        .fix_hi (fix_hi_s),
        .fix_lo (fix_lo_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (zero_div_s) begin
                        next_state_s = ZERO;
                    end else begin
                        next_state_s = RUN;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (count_r == {CW{1'b0}}) begin
                    next_state_s = FIX;
                end else begin
                    next_state_s = RUN;
                end
            end
            FIX:     next_state_s = IDLE;
            ZERO:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Datapath, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r    <= {CW{1'b0}};
            op_div_r   <= 1'b0;
            sign_a_r   <= 1'b0;
            sign_b_r   <= 1'b0;
            operand_r  <= {WIDTH{1'b0}};
            acc_hi_r   <= {WIDTH{1'b0}};
            acc_lo_r   <= {WIDTH{1'b0}};
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_div_r   <= op_div;
                        sign_a_r   <= neg_a_s;
                        sign_b_r   <= neg_b_s;
                        operand_r  <= mag_b_s;
                        acc_hi_r   <= {WIDTH{1'b0}};
                        acc_lo_r   <= mag_a_s;
                        count_r    <= CW'(WIDTH-1);
                        div_zero_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                RUN: begin
                    acc_hi_r <= step_hi_s;
                    acc_lo_r <= step_lo_s;
                    if (count_r != {CW{1'b0}}) begin
                        count_r <= count_r - 1'b1;
                    end
                end
                FIX: begin
                    hi_r   <= fix_hi_s;
                    lo_r   <= fix_lo_s;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                ZERO: begin
                    div_zero_r <= 1'b1;
                    done_r     <= 1'b1;
                    busy_r     <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign hi       = hi_r;
    assign lo       = lo_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed 32-bit multiply/divide unit for the multicycle datapath.
- Sits directly downstream of the ALU operand-A select, in parallel with the ALU; consumes the selected operand A and register B.
- Produces HI/LO results for the mfhi/mflo paths.
- The control FSM raises start and holds its state until done.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only when busy=0.
- op_div  in  1  0 = multiply, 1 = divide.
- src_a  in  WIDTH  multiplicand/dividend (ALU operand-A select output).
- src_b  in  WIDTH  multiplier/divisor (register B).
- hi  out  WIDTH  mult: upper product; div: remainder.
- lo  out  WIDTH  mult: lower product; div: quotient.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; hi/lo valid.
- div_zero  out  1  set with done when the divisor was 0; cleared by the next accepted start.

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, div_zero=0, FSM=IDLE, counter=0. Reset dominates start and aborts any operation mid-flight; hi/lo return to 0.
- States and transitions:
  - IDLE: start=1 latches sign bits and the magnitudes |src_a| and |src_b|, loads counter=WIDTH-1, clears div_zero. Next state is RUN. Exception: op_div=1 with src_b=0 goes to ZERO.
  - RUN: one shift-add (mult) or one restoring shift-subtract (div) step per cycle. Counter decrements; at counter=0 next state is FIX.
  - FIX: apply signs. Product is negated if the operand signs differ. Quotient is negated if the signs differ. Remainder takes the dividend's sign. Write hi/lo, pulse done, go to IDLE.
  - ZERO: div_zero=1, done pulse, hi/lo unchanged, go to IDLE.
- Timing: start accepted at edge k.
  - Normal operation: busy=1 after edge k. hi/lo/done valid after edge k+WIDTH+1. busy=0 in that same cycle. done=0 after edge k+WIDTH+2.
  - Divide-by-zero: done=1 and div_zero=1 after edge k+1.
- start while busy=1 is ignored; no queueing.
- Back-to-back operation: start is accepted in the done cycle, since the FSM is IDLE then.
- src_a/src_b may change after the accepting edge; internal copies are used.
- Arithmetic:
  - The product is a full 2*WIDTH-bit value; no truncation.
  - Magnitude of 0x80000000 is treated as unsigned 2^31.
  - Overflow 0x80000000 / -1 yields lo=0x80000000, hi=0 with no flag.
- hi/lo hold their values until the next completed operation or reset.

Optional Feature:
- MULTDIV_UNSIGNED_EN defined: adds input port is_unsigned (1 bit), sampled with start. When 1, the sign handling in IDLE and FIX is bypassed, giving multu/divu semantics. Latency is unchanged.
- Not defined: the port is absent and all operations are signed.

Decomposition:
- Package multdiv_pkg: state enum (IDLE, RUN, FIX, ZERO), MD_WIDTH=32 constant, op_div encodings (MD_OP_MULT=0, MD_OP_DIV=1).
- One natural combinational sub-module, multdiv_sign_fix. It takes the raw product/quotient/remainder and the sign bits, and outputs the corrected hi/lo.
- The FSM, counter and datapath registers stay in mult_div_unit.

Test Plan:
- Reset then idle: after reset → hi=0, lo=0, busy=0, done=0, div_zero=0.
- Multiply: src_a=7, src_b=0xFFFFFFFD (-3), op_div=0, start → done exactly 33 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Multiply corner case: 0x80000000 * 0x80000000 → hi=0x40000000, lo=0x00000000.
- Signed divide: src_a=0xFFFFFFF9 (-7), src_b=2, op_div=1 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: hi/lo preloaded via 5*6 (lo=30); then 9/0 → done and div_zero after 1 cycle; lo=30 and hi=0 unchanged. The next valid start clears div_zero.
- Control hazards:
  - start pulsed at cycle 5 of a running operation → ignored; the first result is unaffected.
  - reset asserted at cycle 10 → busy=0, hi=lo=0, no done pulse.
  - start in the done cycle → accepted.
